// File: rtl/gpu_noc_pkg.sv
// Shared flit format, origin tag and saturating counter helper for the GPU network interface.
package gpu_noc_pkg;

   localparam int FLIT_W = 16;
   localparam int DEST_W = 6;
   localparam int PAY_W  = FLIT_W - DEST_W;

   typedef struct packed {
      logic [DEST_W-1:0] dest;
      logic [PAY_W-1:0]  payload;
   } flit_t;

   typedef enum logic {
      ORIG_ROUTER = 1'b0,
      ORIG_LOOP   = 1'b1
   } origin_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [1:0] n);
      logic [16:0] s;
      s = {1'b0, v} + {15'd0, n};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// Synchronous FIFO with two ordered write ports (a before b), one read port and an occupancy count.
// The head is read combinationally from storage; callers never push beyond capacity.
module ni_sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_a,
   input  logic [W-1:0]  data_a,
   input  logic          push_b,
   input  logic [W-1:0]  data_b,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_b;

   assign wr_ptr_b = push_a ? wr_ptr + AW'(1) : wr_ptr;
   assign head     = mem[rd_ptr];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
      end
   end

   // Storage carries no reset; consumers mask the head while empty.
   always_ff @(posedge clk) begin
      if (push_a) mem[wr_ptr]   <= data_a;
      if (push_b) mem[wr_ptr_b] <= data_b;
   end

endmodule

// File: rtl/gpu_noc_ni.sv
// GPU network interface: TX FIFO with credit-based router injection, RX FIFO with destination filtering.
// Define NI_LOOPBACK_EN to move self-addressed TX flits straight into RX without using router credits.
module gpu_noc_ni
   import gpu_noc_pkg::*;
#(
   parameter int NODE_ID    = 31,
   parameter int TX_DEPTH   = 8,
   parameter int RX_DEPTH   = 8,
   parameter int TX_CREDITS = 4,
   parameter int RX_CREDITS = 6,
   localparam int TCW = $clog2(TX_DEPTH) + 1,
   localparam int RCW = $clog2(RX_DEPTH) + 1
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [FLIT_W-1:0] gpu_data_in,
   input  logic              gpu_valid_in,
   output logic              gpu_ready_out,
   output logic [FLIT_W-1:0] gpu_data_out,
   output logic              gpu_valid_out,
   input  logic              gpu_ready_in,
   output logic [FLIT_W-1:0] rt_flit_out,
   output logic              rt_valid_out,
   input  logic              rt_credit_in,
   input  logic [FLIT_W-1:0] rt_flit_in,
   input  logic              rt_valid_in,
   output logic              rt_credit_out,
   output logic [TCW-1:0]    tx_count,
   output logic [RCW-1:0]    rx_count,
   output logic [15:0]       drop_count,
   output logic              credit_err
);

   localparam logic [DEST_W-1:0] MY_ID = DEST_W'(NODE_ID);
   localparam int CRW = $clog2(TX_CREDITS + 1) + 1;
   localparam int PW  = $clog2(RX_CREDITS + 1) + 1;
`ifdef NI_LOOPBACK_EN
   localparam int RXW = FLIT_W + 1;
`else
   localparam int RXW = FLIT_W;
`endif

   flit_t          tx_head, rt_in;
   logic           tx_full, tx_empty, tx_push, tx_pop, tx_drop, inject, lb_push, credit_ovf;
   logic [TCW-1:0] tx_next;
   logic [CRW-1:0] tx_credit;
   logic [RXW-1:0] rx_head, rt_entry, lb_entry;
   logic           rx_full, rx_empty, rx_pop, rt_push, rx_drop, rx_viol, cr_mis, cr_pop;
   logic [PW-1:0]  pend, cr_total;

   assign rt_in = rt_flit_in;

`ifdef NI_LOOPBACK_EN
   logic           head_self, head_loop;
   logic [RCW-1:0] loop_cnt;

   assign head_self    = !tx_empty && (tx_head.dest == MY_ID);
   // Router entries are bounded by its credits, so capping loopback entries keeps RX from overflowing.
   assign lb_push      = head_self && !rx_full && (loop_cnt < RCW'(RX_DEPTH - RX_CREDITS));
   assign inject       = !tx_empty && !head_self && (tx_credit != '0);
   assign rt_entry     = {ORIG_ROUTER, rt_flit_in};
   assign lb_entry     = {ORIG_LOOP, tx_head};
   assign head_loop    = (origin_t'(rx_head[FLIT_W]) == ORIG_LOOP);
   assign cr_pop       = rx_pop && !head_loop;
   assign gpu_data_out = rx_empty ? '0 : rx_head[FLIT_W-1:0];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) loop_cnt <= '0;
      else          loop_cnt <= loop_cnt + RCW'(lb_push) - RCW'(rx_pop && head_loop);
   end
`else
   assign lb_push      = 1'b0;
   assign inject       = !tx_empty && (tx_credit != '0);
   assign rt_entry     = rt_flit_in;
   assign lb_entry     = '0;
   assign cr_pop       = rx_pop;
   assign gpu_data_out = rx_empty ? '0 : rx_head;
`endif

   // A full TX FIFO still accepts a flit in a cycle where its head leaves.
   assign tx_pop     = inject || lb_push;
   assign tx_push    = gpu_valid_in && (!tx_full || tx_pop);
   assign tx_drop    = gpu_valid_in && !tx_push;
   assign tx_next    = tx_count + TCW'(tx_push) - TCW'(tx_pop);
   assign credit_ovf = rt_credit_in && !inject && (tx_credit == CRW'(TX_CREDITS));

   assign rx_viol       = rt_valid_in && rx_full;
   assign rt_push       = rt_valid_in && !rx_full && (rt_in.dest == MY_ID);
   assign cr_mis        = rt_valid_in && !rx_full && (rt_in.dest != MY_ID);
   assign rx_drop       = rx_viol || cr_mis;
   assign rx_pop        = !rx_empty && gpu_ready_in;
   assign gpu_valid_out = !rx_empty;
   assign cr_total      = pend + PW'(cr_mis) + PW'(cr_pop);

   ni_sync_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(ACLK), .rst_n(ARESETn),
      .push_a(tx_push), .data_a(gpu_data_in),
      .push_b(1'b0), .data_b('0),
      .pop(tx_pop), .head(tx_head), .count(tx_count),
      .full(tx_full), .empty(tx_empty)
   );

   ni_sync_fifo #(.W(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(ACLK), .rst_n(ARESETn),
      .push_a(rt_push), .data_a(rt_entry),
      .push_b(lb_push), .data_b(lb_entry),
      .pop(rx_pop), .head(rx_head), .count(rx_count),
      .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rt_flit_out   <= '0;
         rt_valid_out  <= 1'b0;
         tx_credit     <= CRW'(TX_CREDITS);
         credit_err    <= 1'b0;
         drop_count    <= '0;
         gpu_ready_out <= 1'b1;
         rt_credit_out <= 1'b0;
         pend          <= '0;
      end else begin
         rt_valid_out <= inject;
         if (inject) rt_flit_out <= tx_head;
         if (inject && !rt_credit_in)                       tx_credit <= tx_credit - CRW'(1);
         else if (rt_credit_in && !inject && !credit_ovf)   tx_credit <= tx_credit + CRW'(1);
         credit_err    <= credit_err || credit_ovf || rx_viol;
         drop_count    <= sat_inc(drop_count, 2'(tx_drop) + 2'(rx_drop));
         gpu_ready_out <= (tx_next <= TCW'(TX_DEPTH - 2));
         // At most one credit pulse per cycle; any surplus waits in pend.
         rt_credit_out <= (cr_total != '0);
         pend          <= (cr_total != '0) ? cr_total - PW'(1) : '0;
      end
   end

endmodule

// File: doc/gpu_noc_ni.md
Name: gpu_noc_ni

Overview:
- Network interface between one GPU's 16-bit net_* port and its mesh router port.
- Egress: buffers GPU flits in a TX FIFO and injects them into the router under credit-based flow control.
- Ingress: accepts credited flits from the router, checks the destination field, and buffers flits for the GPU with valid/ready delivery.
- Flit format: {dest[DEST_W-1:0], payload[FLIT_W-DEST_W-1:0]}.

Parameters:
- NODE_ID, 31: this node's ID; compared against the dest field.
- FLIT_W, 16: flit width.
- DEST_W, 6: dest field width; occupies the flit MSBs.
- TX_DEPTH, 8: TX FIFO entries; power of 2, at least 4.
- RX_DEPTH, 8: RX FIFO entries; power of 2, at least 4.
- TX_CREDITS, 4: initial credits for the router input buffer.
- RX_CREDITS, 6: credits granted to the router; at most RX_DEPTH.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  async active-low reset.
- gpu_data_in  in  FLIT_W  flit from GPU.
- gpu_valid_in  in  1  GPU flit valid; may be a single-cycle pulse.
- gpu_ready_out  out  1  TX can accept (early-warning ready).
- gpu_data_out  out  FLIT_W  flit to GPU.
- gpu_valid_out  out  1  RX head valid.
- gpu_ready_in  in  1  GPU accepts.
- rt_flit_out  out  FLIT_W  flit to router.
- rt_valid_out  out  1  one-cycle pulse per injected flit.
- rt_credit_in  in  1  router frees one buffer slot.
- rt_flit_in  in  FLIT_W  flit from router.
- rt_valid_in  in  1  router flit valid; always credited.
- rt_credit_out  out  1  one-cycle pulse, one RX slot freed.
- tx_count  out  $clog2(TX_DEPTH)+1  TX occupancy.
- rx_count  out  $clog2(RX_DEPTH)+1  RX occupancy.
- drop_count  out  16  dropped flits; saturating.
- credit_err  out  1  sticky; credit overflow.

Behaviour:
Reset (ARESETn async active-low; clock ACLK):
- FIFOs empty; tx_credit = TX_CREDITS.
- All outputs 0 except gpu_ready_out = 1.

TX side:
- Push on gpu_valid_in whenever the TX FIFO is not full. This is valid-only acceptance because the GPU samples ready one cycle early.
- gpu_valid_in while full: flit dropped, drop_count++.
- gpu_ready_out is registered: 1 iff tx_count <= TX_DEPTH-2 after this cycle's updates. This leaves one skid slot.

Injection:
- Condition: TX non-empty and tx_credit > 0.
- Registered: pop head, rt_flit_out <= head, rt_valid_out <= 1 for one cycle, tx_credit--.
- Throughput: 1 flit/cycle max.
- rt_credit_in increments tx_credit.
- Injection and credit in the same cycle: tx_credit unchanged.
- tx_credit would exceed TX_CREDITS: saturate and set credit_err.
- TX push and pop in the same cycle: tx_count unchanged; a full FIFO may pop and push in the same cycle.

RX side:
- rt_valid_in with dest == NODE_ID: push into RX (origin tag = router).
- rt_valid_in with dest != NODE_ID: drop, drop_count++, rt_credit_out pulses next cycle.
- rt_valid_in while RX is full is a protocol violation: drop, drop_count++, set credit_err.
- gpu_data_out / gpu_valid_out are the registered RX head; held stable until gpu_valid_out && gpu_ready_in.
- Latency: a flit pushed into an empty RX gives gpu_valid_out 1 cycle later.
- On pop of a router-origin entry, rt_credit_out pulses 1 cycle.
- A misroute credit and a pop credit in the same cycle: return one now, queue one (pending-credit counter). No credit is ever lost.

Counters and reset:
- drop_count saturates at 16'hFFFF.
- Async reset mid-transfer: all state discarded immediately; credits reinitialised. The router is reset by the same ARESETn.

Optional Feature:
Macro NI_LOOPBACK_EN.
- Defined:
  - TX head with dest == NODE_ID bypasses the router and moves into the RX FIFO with origin tag = loopback. No tx_credit is used and no rt_credit_out is generated on its pop.
  - Allowed only while loopback entries in RX < RX_DEPTH-RX_CREDITS and RX not full; otherwise the TX head stalls.
  - A router push and a loopback push in the same cycle both push (2-write-port RX).
- Not defined: self-addressed flits are injected to the router like any other flit; the origin-tag bit is removed.

Decomposition:
- Package gpu_noc_pkg:
  - flit_t struct {dest, payload}.
  - DEST_W, FLIT_W.
  - Origin-tag enum {ORIG_ROUTER, ORIG_LOOP}.
  - Saturating-increment function.
- Sub-module ni_sync_fifo (parameterised width/depth, count output, full/empty), instantiated for TX and RX. RX width is FLIT_W+1 when loopback is enabled.

Test Plan:
- Reset, then GPU pulses 16'h8123 (dest 32) → rt_valid_out pulse with 16'h8123 two cycles later; tx_credit 4→3; rt_credit_in restores it to 4.
- Inject 6 flits with rt_credit_in held 0 → 4 sent, 2 held in TX; gpu_ready_out=0 only at tx_count >= 7; each later credit releases one flit.
- 9 back-to-back GPU pulses with credits blocked → 8 buffered, 9th dropped, drop_count=1.
- Router sends 16'h7C55 (dest 31) → gpu_data_out=16'h7C55, valid 1 cycle later; held while gpu_ready_in=0 for 3 cycles; rt_credit_out pulses once after acceptance.
- Router sends 16'h0455 (dest 1) → no gpu_valid_out, drop_count++, rt_credit_out pulse; coincident with a GPU pop → two credit pulses on consecutive cycles.
- With NI_LOOPBACK_EN: GPU sends 16'h7C01 → appears on gpu_data_out with no rt_valid_out and tx_credit unchanged; a third loopback flit stalls in TX until the GPU pops.
